// File: rtl/config_pkg.sv
// Global cache/memory geometry shared by the frontend blocks.
package config_pkg;

    typedef struct packed {
        int unsigned PLEN;
        int unsigned ICACHE_LINE_WIDTH;
        int unsigned ICACHE_OFFSET_WIDTH;
        int unsigned ICACHE_SET_ASSOC_WIDTH;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{
        PLEN:                   32,
        ICACHE_LINE_WIDTH:      256,
        ICACHE_OFFSET_WIDTH:    5,
        ICACHE_SET_ASSOC_WIDTH: 2
    };

endpackage

// File: rtl/icache_refill_unit.sv
// ICache miss refill engine: one line-aligned memory read per miss, beats assembled
// into a line buffer and returned with address and victim way; flush drains safely.
module icache_refill_unit #(
    parameter config_pkg::cfg_t Cfg       = config_pkg::EmptyCfg,
    parameter int unsigned      BUS_WIDTH = 64,
    parameter int unsigned      NUM_BEATS = Cfg.ICACHE_LINE_WIDTH / BUS_WIDTH
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  flush_i,
    input  logic                                  miss_valid_i,
    output logic                                  miss_ready_o,
    input  logic [Cfg.PLEN-1:0]                   miss_paddr_i,
    input  logic [Cfg.ICACHE_SET_ASSOC_WIDTH-1:0] miss_way_i,
    output logic                                  mem_req_valid_o,
    input  logic                                  mem_req_ready_i,
    output logic [Cfg.PLEN-1:0]                   mem_req_addr_o,
    input  logic                                  mem_rsp_valid_i,
    output logic                                  mem_rsp_ready_o,
    input  logic [BUS_WIDTH-1:0]                  mem_rsp_data_i,
    output logic                                  refill_valid_o,
    input  logic                                  refill_ready_i,
    output logic [Cfg.PLEN-1:0]                   refill_paddr_o,
    output logic [Cfg.ICACHE_SET_ASSOC_WIDTH-1:0] refill_way_o,
    output logic [Cfg.ICACHE_LINE_WIDTH-1:0]      refill_line_o,
    output logic                                  busy_o
);

    // state | meaning
    // IDLE  | waiting for a miss
    // REQ   | line read request held until memory accepts it
    // BEATS | collecting NUM_BEATS data beats (always drained, even when dropping)
    // RESP  | assembled line offered to the ICache

    localparam int unsigned PLEN = Cfg.PLEN;
    localparam int unsigned LW   = Cfg.ICACHE_LINE_WIDTH;
    localparam int unsigned OW   = Cfg.ICACHE_OFFSET_WIDTH;
    localparam int unsigned WW   = Cfg.ICACHE_SET_ASSOC_WIDTH;
    localparam int unsigned CW   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    localparam logic [CW-1:0]   LAST_CNT    = CW'(NUM_BEATS - 1);
    localparam logic [PLEN-1:0] OFFSET_MASK = {{(PLEN-OW){1'b0}}, {OW{1'b1}}};

    typedef enum logic [1:0] {IDLE, REQ, BEATS, RESP} state_t;

    state_t          state_q, state_d;
    logic [PLEN-1:0] line_addr_q;
    logic [WW-1:0]   way_q;
    logic [LW-1:0]   line_q;
    logic [CW-1:0]   cnt_q;
    logic            drop_q;
    logic [PLEN-1:0] out_addr_q;
    logic [WW-1:0]   out_way_q;
    logic [LW-1:0]   out_line_q;

    logic miss_hs, beat_hs, last_beat, to_resp;

    assign miss_hs   = (state_q == IDLE) & miss_valid_i & ~flush_i;
    assign beat_hs   = (state_q == BEATS) & mem_rsp_valid_i;
    assign last_beat = beat_hs & (cnt_q == LAST_CNT);
    assign to_resp   = last_beat & ~drop_q & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (miss_hs) state_d = REQ;
            REQ:   if (mem_req_ready_i) state_d = BEATS;
            BEATS: if (last_beat) state_d = to_resp ? RESP : IDLE;
            RESP:  if (flush_i || refill_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        miss_ready_o    = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_rsp_ready_o = 1'b0;
        refill_valid_o  = 1'b0;
        busy_o          = (state_q != IDLE);
        case (state_q)
            IDLE:  miss_ready_o    = ~flush_i;
            REQ:   mem_req_valid_o = 1'b1;
            BEATS: mem_rsp_ready_o = 1'b1;
            RESP:  refill_valid_o  = ~flush_i;
            default: ;
        endcase
    end

    // Output copies are loaded only when a refill is offered, so they hold across later misses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_addr_q <= '0;
            way_q       <= '0;
            line_q      <= '0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            out_addr_q  <= '0;
            out_way_q   <= '0;
            out_line_q  <= '0;
        end else begin
            if (miss_hs) begin
                line_addr_q <= miss_paddr_i & ~OFFSET_MASK;
                way_q       <= miss_way_i;
                cnt_q       <= '0;
                drop_q      <= 1'b0;
            end else if (flush_i && (state_q == REQ || state_q == BEATS)) begin
                drop_q <= 1'b1;
            end
            if (beat_hs) begin
                cnt_q <= last_beat ? '0 : cnt_q + CW'(1);
                for (int b = 0; b < NUM_BEATS; b++) begin
                    if (cnt_q == CW'(b)) begin
                        line_q[b*BUS_WIDTH +: BUS_WIDTH] <= mem_rsp_data_i;
                    end
                end
            end
            if (to_resp) begin
                out_addr_q <= line_addr_q;
                out_way_q  <= way_q;
                for (int b = 0; b < NUM_BEATS; b++) begin
                    out_line_q[b*BUS_WIDTH +: BUS_WIDTH] <= (b == NUM_BEATS - 1) ?
                        mem_rsp_data_i : line_q[b*BUS_WIDTH +: BUS_WIDTH];
                end
            end
        end
    end

    assign mem_req_addr_o = line_addr_q;
    assign refill_paddr_o = out_addr_q;
    assign refill_way_o   = out_way_q;
    assign refill_line_o  = out_line_q;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed and randomized refills checked against a transaction-level model of the
// refill unit (expected line, address, latency and drop outcome per miss).
module tb_icache_refill_unit;

    localparam int F_REQ  = 1;
    localparam int F_BEAT = 2;
    localparam int F_LAST = 4;
    localparam int F_RESP = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         miss_valid;
    logic         miss_ready;
    logic [31:0]  miss_paddr;
    logic [1:0]   miss_way;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid;
    logic         mem_rsp_ready;
    logic [63:0]  mem_rsp_data;
    logic         refill_valid;
    logic         refill_ready;
    logic [31:0]  refill_paddr;
    logic [1:0]   refill_way;
    logic [255:0] refill_line;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_refill_unit dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .miss_valid_i    (miss_valid),
        .miss_ready_o    (miss_ready),
        .miss_paddr_i    (miss_paddr),
        .miss_way_i      (miss_way),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_ready_o (mem_rsp_ready),
        .mem_rsp_data_i  (mem_rsp_data),
        .refill_valid_o  (refill_valid),
        .refill_ready_i  (refill_ready),
        .refill_paddr_o  (refill_paddr),
        .refill_way_o    (refill_way),
        .refill_line_o   (refill_line),
        .busy_o          (busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_miss_ready"},    miss_ready,    1);
        chk({pfx, "_busy"},          busy,          0);
        chk({pfx, "_mem_req_valid"}, mem_req_valid, 0);
        chk({pfx, "_mem_req_addr"},  mem_req_addr,  0);
        chk({pfx, "_mem_rsp_ready"}, mem_rsp_ready, 0);
        chk({pfx, "_refill_valid"},  refill_valid,  0);
        chk({pfx, "_refill_paddr"},  refill_paddr,  0);
        chk({pfx, "_refill_way"},    refill_way,    0);
        chk({pfx, "_refill_line"},   refill_line,   0);
    endtask

    // One miss transaction; the expected outcome follows from which flushes are applied.
    task automatic do_miss(input logic [31:0] pa, input logic [1:0] w, input int req_stall,
                           input int max_gap, input int rsp_stall, input int fmode,
                           input bit check_lat);
        logic [63:0]  beats [4];
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        bit           drop;
        int           cyc;
        int           i;
        int           gap;
        int           guard;
        bit           flushed_beat;

        exp_addr = {pa[31:5], 5'b0};
        for (int k = 0; k < 4; k++) begin
            beats[k] = {$urandom, $urandom};
            exp_line[k*64 +: 64] = beats[k];
        end
        drop = (fmode & (F_REQ | F_BEAT | F_LAST)) != 0;
        cyc  = 0;

        @(negedge clk);
        miss_valid = 1'b1;
        miss_paddr = pa;
        miss_way   = w;
        #1;
        chk("accept_miss_ready", miss_ready, 1);
        chk("accept_busy", busy, 0);

        for (int s = 0; s <= req_stall; s++) begin
            @(negedge clk);
            cyc++;
            miss_valid    = 1'b0;
            miss_paddr    = $urandom;
            mem_req_ready = (s == req_stall);
            flush         = ((fmode & F_REQ) != 0) && (s == 0);
            #1;
            chk("req_valid", mem_req_valid, 1);
            chk("req_addr", mem_req_addr, exp_addr);
            chk("req_rsp_ready", mem_rsp_ready, 0);
            chk("req_busy", busy, 1);
            chk("req_refill_valid", refill_valid, 0);
        end

        i = 0;
        guard = 0;
        flushed_beat = 1'b0;
        gap = $urandom_range(0, max_gap);
        while (i < 4 && guard < 64) begin
            @(negedge clk);
            cyc++;
            guard++;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            flush         = 1'b0;
            if (((fmode & F_BEAT) != 0) && i == 2 && !flushed_beat) begin
                flush = 1'b1;
                flushed_beat = 1'b1;
            end else if (gap > 0) begin
                gap--;
            end else begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = beats[i];
                flush         = ((fmode & F_LAST) != 0) && (i == 3);
            end
            #1;
            chk("beat_rsp_ready", mem_rsp_ready, 1);
            chk("beat_req_valid", mem_req_valid, 0);
            chk("beat_refill_valid", refill_valid, 0);
            if (mem_rsp_valid) begin
                i++;
                gap = $urandom_range(0, max_gap);
            end
        end
        chk("beats_drained", i, 4);

        @(negedge clk);
        cyc++;
        mem_rsp_valid = 1'b0;
        flush         = 1'b0;
        if (drop) begin
            #1;
            chk("drop_busy", busy, 0);
            chk("drop_refill_valid", refill_valid, 0);
            chk("drop_miss_ready", miss_ready, 1);
        end else if ((fmode & F_RESP) != 0) begin
            refill_ready = 1'b0;
            flush        = 1'b1;
            #1;
            chk("respflush_valid", refill_valid, 0);
            chk("respflush_busy", busy, 1);
            @(negedge clk);
            flush = 1'b0;
            #1;
            chk("respflush_idle", busy, 0);
            chk("respflush_miss_ready", miss_ready, 1);
            chk("respflush_refill_valid", refill_valid, 0);
        end else begin
            for (int s = 0; s <= rsp_stall; s++) begin
                if (s > 0) begin
                    @(negedge clk);
                    cyc++;
                end
                refill_ready = (s == rsp_stall);
                #1;
                if (s == 0 && check_lat) chk("latency", cyc, 6);
                chk("resp_valid", refill_valid, 1);
                chk("resp_paddr", refill_paddr, exp_addr);
                chk("resp_way", refill_way, w);
                chk("resp_line", refill_line, exp_line);
            end
            @(negedge clk);
            refill_ready = 1'b0;
            #1;
            chk("post_busy", busy, 0);
            chk("post_miss_ready", miss_ready, 1);
            chk("post_refill_valid", refill_valid, 0);
            chk("post_line_hold", refill_line, exp_line);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        miss_valid    = 1'b0;
        miss_paddr    = '0;
        miss_way      = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        refill_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        do_miss(32'h8000_0014, 2'd2, 0, 0, 0, 0, 1'b1);
        do_miss(32'h1234_567f, 2'd1, 3, 2, 4, 0, 1'b0);
        do_miss(32'h0000_0040, 2'd3, 1, 1, 0, F_REQ | F_BEAT, 1'b0);
        do_miss(32'hdead_beef, 2'd0, 0, 1, 0, F_LAST, 1'b0);
        do_miss(32'hcafe_0001, 2'd1, 0, 0, 2, F_RESP, 1'b0);
        do_miss(32'h4000_0020, 2'd3, 0, 0, 0, 0, 1'b1);

        @(negedge clk);
        flush      = 1'b1;
        miss_valid = 1'b1;
        miss_paddr = 32'h5555_5555;
        #1;
        chk("flushmiss_ready", miss_ready, 0);
        @(negedge clk);
        flush      = 1'b0;
        miss_valid = 1'b0;
        #1;
        chk("flushmiss_busy", busy, 0);
        chk("flushmiss_req_valid", mem_req_valid, 0);

        @(negedge clk);
        miss_valid = 1'b1;
        miss_paddr = 32'h7777_7777;
        miss_way   = 2'd1;
        @(negedge clk);
        miss_valid    = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'h1111;
        @(negedge clk);
        mem_rsp_data  = 64'h2222;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        chk("prerst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        do_miss(32'h0bad_f00d, 2'd2, 0, 0, 0, 0, 1'b1);

        for (int k = 0; k < 12; k++) begin
            int fm;
            fm = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 15));
            do_miss($urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom_range(0, 3), fm, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_refill_unit.md
# icache_refill_unit

Miss-side refill engine for the instruction cache. It accepts one line-miss request at a time from the ICache and issues a line-aligned read to the memory side. It collects the line as a sequence of bus-width beats, then returns the assembled line, its address and the victim way to the ICache for installation. A frontend flush drops an in-flight refill without violating either handshake.

## Interface

Parameters:

- `Cfg`, default `config_pkg::EmptyCfg`: global configuration. Uses `PLEN`, `ICACHE_LINE_WIDTH` (bits), `ICACHE_OFFSET_WIDTH` and `ICACHE_SET_ASSOC_WIDTH`.
- `BUS_WIDTH`, default 64: memory data beat width in bits. `ICACHE_LINE_WIDTH` must be a multiple of `BUS_WIDTH`.
- `NUM_BEATS`, default `Cfg.ICACHE_LINE_WIDTH/BUS_WIDTH`: derived, not overridden.

Ports. The block has one clock; reset is asynchronous and active-high.

- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `flush_i` in 1: frontend redirect/flush; drops the current refill.
- `miss_valid_i` in 1: miss request valid.
- `miss_ready_o` out 1: miss request accepted.
- `miss_paddr_i` in `PLEN`: missing physical address (any byte offset).
- `miss_way_i` in `ICACHE_SET_ASSOC_WIDTH`: victim way chosen by the ICache.
- `mem_req_valid_o` out 1: memory read request valid.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_req_addr_o` out `PLEN`: line-aligned read address.
- `mem_rsp_valid_i` in 1: data beat valid.
- `mem_rsp_ready_o` out 1: unit accepts the beat.
- `mem_rsp_data_i` in `BUS_WIDTH`: beat data, lowest address first.
- `refill_valid_o` out 1: assembled line valid.
- `refill_ready_i` in 1: ICache installs the line.
- `refill_paddr_o` out `PLEN`: line-aligned address of the line.
- `refill_way_o` out `ICACHE_SET_ASSOC_WIDTH`: victim way.
- `refill_line_o` out `ICACHE_LINE_WIDTH`: line data.
- `busy_o` out 1: high whenever the state is not `IDLE`.

## Operation

- The FSM has four states: `IDLE`, `REQ`, `BEATS`, `RESP`. It also holds these registers: `line_addr`, `way`, `line` buffer, beat counter `cnt` (width `$clog2(NUM_BEATS)`, minimum 1) and a `drop` flag.
- `IDLE`:
  - `miss_ready_o = ~flush_i`.
  - On `miss_valid_i & miss_ready_o`, latch `line_addr = miss_paddr_i` with its low `ICACHE_OFFSET_WIDTH` bits cleared, latch `way`, clear `cnt` and `drop`, then go to `REQ`.
- `REQ`:
  - `mem_req_valid_o = 1` and `mem_req_addr_o = line_addr`.
  - Valid is held until `mem_req_ready_i` arrives and is never withdrawn, even on flush.
  - On the handshake, go to `BEATS`.
- `BEATS`:
  - `mem_rsp_ready_o = 1`.
  - Each accepted beat writes `line[cnt*BUS_WIDTH +: BUS_WIDTH]` and increments `cnt`.
  - On the beat with `cnt == NUM_BEATS-1`, `cnt` wraps to 0. The FSM goes to `RESP` if `drop` is 0 and no flush occurs that cycle; otherwise it goes to `IDLE`.
  - Beats are never discarded early. All `NUM_BEATS` beats are drained even when dropping.
- `RESP`:
  - `refill_valid_o = ~flush_i`.
  - `refill_paddr_o`, `refill_way_o` and `refill_line_o` are stable register outputs.
  - On `refill_valid_o & refill_ready_i`, go to `IDLE`.
  - `flush_i` in `RESP` goes to `IDLE` with no transfer.
- Flush in `REQ` or `BEATS` sets `drop`. `drop` is cleared only on a new miss acceptance.
- `mem_req_valid_o` and `mem_rsp_ready_o` are 0 outside `REQ` and `BEATS` respectively.
- `refill_*` data outputs hold their last value outside `RESP`.

## Timing

- Reset state is `IDLE`. Every output is 0 except `miss_ready_o = 1`. `line`, `line_addr`, `way`, `cnt` and `drop` reset to 0.
- A miss is accepted in cycle 0. `mem_req_valid_o` rises in cycle 1.
- The first beat can be accepted at the earliest in the cycle after the request handshake.
- `refill_valid_o` rises the cycle after the last beat.
- Minimum miss-to-refill latency with zero memory wait is `NUM_BEATS + 2` cycles: accept, request, then beats.
- After the refill handshake, the next miss is accepted at the earliest one cycle later, in `IDLE`. There is no back-to-back overlap.
- Simultaneous `flush_i` and `miss_valid_i` in `IDLE`: the miss is not accepted.
- Simultaneous `flush_i` and the last beat: the beat is consumed and the FSM goes to `IDLE` with no refill.
- Reset asserted mid-operation returns the FSM to `IDLE` immediately. The memory side is reset in the same domain.

## Test plan

- Basic refill. Use `LINE_WIDTH=256`, `BUS_WIDTH=64`, memory with zero wait. Send a miss at `0x8000_0014` with way 2. Required: `mem_req_addr_o = 0x8000_0000` in cycle 1, and `refill_valid_o` in cycle 6 with `refill_line_o = {b3,b2,b1,b0}` and `refill_way_o = 2`.
- Backpressure. Hold `mem_req_ready_i` low for 3 cycles, gap beats with `mem_rsp_valid_i` low, and hold `refill_ready_i` low for 4 cycles. Required: request valid and address stable throughout; the line is correct; outputs are stable until the handshake.
- Flush in `REQ`, then flush in `BEATS` after beat 1. Required: the request still completes; all 4 beats are accepted; `refill_valid_o` never asserts; `miss_ready_o = 1` afterwards.
- Flush coincident with the last beat, and separately flush during `RESP` with `refill_ready_i` low. Required: no refill handshake; the FSM is back in `IDLE` next cycle.
- `flush_i` and `miss_valid_i` together in `IDLE`. Required: `miss_ready_o = 0` and no memory request. Then assert `rst_i` during `BEATS`. Required: all outputs return to reset values and the next miss completes normally.
